usr_shift_sequencer: RTL and testbench

//  Command-driven controller for one Universal_Shift_Register instance.

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_shift_counter.sv | 28 ++
 rtl/usr_shift_sequencer.sv | 153 +++++++++++++++
 tb/tb_usr_shift_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register sequencer: command opcodes,
// register mode encodings and controller states.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_SHR  = 2'd1,
    OP_SHL  = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_SETTLE,
    ST_RESP
  } state_e;

  // Register mode applied while a shift/hold command is running.
  function automatic logic [1:0] shift_mode(op_e op);
    case (op)
      OP_SHR:  return MODE_SHR;
      OP_SHL:  return MODE_SHL;
      default: return MODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Loadable down-counter that times the SHIFT phase; last flags the final cycle.
module usr_shift_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  // Load on command acceptance, count down while shifting, never wrap below 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven sequencer for one universal shift register.
// Optional feature: define USR_ROTATE_EN to add cmd_rotate, which makes shifts
// recirculate the register's outgoing bit instead of using the fill bit.
//
//   state  | meaning
//   IDLE   | waiting for a command, cmd_ready high
//   LOAD   | mode 11 for one cycle, I_par driven with the latched data
//   SHIFT  | shift/hold mode for count_r cycles
//   SETTLE | mode 00 for one cycle, A_par captured on exit
//   RESP   | response presented until rsp_ready
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
`ifdef USR_ROTATE_EN
  input  logic             cmd_rotate,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             usr_s0,
  output logic             usr_s1,
  output logic [WIDTH-1:0] usr_I_par,
  output logic             usr_MSB_in,
  output logic             usr_LSB_in,
  input  logic [WIDTH-1:0] usr_A_par
);

  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(WIDTH);

  state_e           state, state_nxt;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic             fill_r;
  logic [CNT_W-1:0] count_sat;
  logic             cmd_accept;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [1:0]       mode;
  logic             ser_right, ser_left;
`ifdef USR_ROTATE_EN
  logic             rotate_r;
`endif

  // Counts beyond the register width would only refill it with the same bit.
  assign count_sat  = (cmd_count > COUNT_MAX) ? COUNT_MAX : cmd_count;
  assign cmd_ready  = reset && (state == ST_IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign usr_s1     = mode[1];
  assign usr_s0     = mode[0];

  usr_shift_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (count_sat),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Command fields latched at acceptance; response captured leaving SETTLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_r     <= OP_HOLD;
      data_r   <= '0;
      fill_r   <= 1'b0;
      rsp_data <= '0;
`ifdef USR_ROTATE_EN
      rotate_r <= 1'b0;
`endif
    end else begin
      if (cmd_accept) begin
        op_r   <= op_e'(cmd_op);
        data_r <= cmd_data;
        fill_r <= cmd_fill;
`ifdef USR_ROTATE_EN
        rotate_r <= cmd_rotate;
`endif
      end
      if (state == ST_SETTLE) rsp_data <= usr_A_par;
    end
  end

  // Serial bit entering the register on each side while shifting.
  always_comb begin
`ifdef USR_ROTATE_EN
    ser_right = rotate_r ? usr_A_par[0]       : fill_r;
    ser_left  = rotate_r ? usr_A_par[WIDTH-1] : fill_r;
`else
    ser_right = fill_r;
    ser_left  = fill_r;
`endif
  end

  // Next-state and register-side outputs decoded from the state.
  always_comb begin
    state_nxt  = state;
    mode       = MODE_HOLD;
    usr_I_par  = '0;
    usr_MSB_in = 1'b0;
    usr_LSB_in = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_accept) begin
          if (op_e'(cmd_op) == OP_LOAD) begin
            state_nxt = ST_LOAD;
          end else if (count_sat != '0) begin
            state_nxt = ST_SHIFT;
            cnt_load  = 1'b1;
          end else begin
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_LOAD: begin
        mode      = MODE_LOAD;
        usr_I_par = data_r;
        state_nxt = ST_SETTLE;
      end
      ST_SHIFT: begin
        mode    = shift_mode(op_r);
        cnt_dec = 1'b1;
        if (op_r == OP_SHR) usr_MSB_in = ser_right;
        if (op_r == OP_SHL) usr_LSB_in = ser_left;
        if (cnt_last) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer with a behavioural universal shift
// register attached. Expected values are hand-computed constants.
module tb_usr_shift_sequencer;
  import usr_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             cmd_fill = 1'b0;
`ifdef USR_ROTATE_EN
  logic             cmd_rotate = 1'b0;
  logic             rot_sel = 1'b0;
`endif
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic             usr_s0, usr_s1;
  logic [WIDTH-1:0] usr_I_par;
  logic             usr_MSB_in, usr_LSB_in;
  logic [WIDTH-1:0] a_par = '0;

  int n_checks = 0;
  int n_err    = 0;
  int mode_cnt, lat, bad_ser;

  always #5 clk = ~clk;

  usr_shift_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .cmd_fill   (cmd_fill),
`ifdef USR_ROTATE_EN
    .cmd_rotate (cmd_rotate),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .usr_s0     (usr_s0),
    .usr_s1     (usr_s1),
    .usr_I_par  (usr_I_par),
    .usr_MSB_in (usr_MSB_in),
    .usr_LSB_in (usr_LSB_in),
    .usr_A_par  (a_par)
  );

  // Universal shift register: 00 hold, 01 right (MSB_in enters), 10 left, 11 load.
  always @(posedge clk) begin
    case ({usr_s1, usr_s0})
      2'b01:   a_par <= {usr_MSB_in, a_par[WIDTH-1:1]};
      2'b10:   a_par <= {a_par[WIDTH-2:0], usr_LSB_in};
      2'b11:   a_par <= usr_I_par;
      default: a_par <= a_par;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then follow it until rsp_valid. lat counts edges after
  // the acceptance edge; mode_cnt counts cycles showing want_mode.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] count, input logic fill,
                         input logic [1:0] want_mode);
    logic found;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    cmd_fill  = fill;
`ifdef USR_ROTATE_EN
    cmd_rotate = rot_sel;
`endif
    tick;
    cmd_valid = 1'b0;
    mode_cnt = 0;
    bad_ser  = 0;
    lat      = 0;
    found    = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (rsp_valid) begin
        lat   = k;
        found = 1'b1;
        break;
      end
      if ({usr_s1, usr_s0} == want_mode) mode_cnt++;
      if (({usr_s1, usr_s0} != MODE_SHR) && usr_MSB_in) bad_ser++;
      if (({usr_s1, usr_s0} != MODE_SHL) && usr_LSB_in) bad_ser++;
      tick;
    end
    if (!found) chk("rsp_timeout", 0, 1);
    chk("serial_unused", bad_ser, 0);
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1;
    chk("rst_mode", {usr_s1, usr_s0}, 2'b00);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_i_par", usr_I_par, 0);
    chk("rst_serial", {usr_MSB_in, usr_LSB_in}, 2'b00);
    tick;
    reset = 1'b1;
    tick;

    // 1: load
    run_cmd(OP_LOAD, 4'b1010, 3'd0, 1'b0, MODE_LOAD);
    chk("load_mode_cycles", mode_cnt, 1);
    chk("load_latency", lat, 2);
    chk("load_rsp", rsp_data, 4'b1010);
    finish_rsp;

    // 2: shift left by 2 with fill 1, then a zero-count shift
    run_cmd(OP_SHL, 4'b0000, 3'd2, 1'b1, MODE_SHL);
    chk("shl2_mode_cycles", mode_cnt, 2);
    chk("shl2_rsp", rsp_data, 4'b1011);
    finish_rsp;
    run_cmd(OP_SHL, 4'b0000, 3'd0, 1'b1, MODE_SHL);
    chk("shl0_mode_cycles", mode_cnt, 0);
    chk("shl0_latency", lat, 1);
    chk("shl0_rsp", rsp_data, 4'b1011);
    finish_rsp;

    // 3: saturating shift right
    run_cmd(OP_LOAD, 4'b1111, 3'd0, 1'b0, MODE_LOAD);
    chk("load_f_rsp", rsp_data, 4'b1111);
    finish_rsp;
    run_cmd(OP_SHR, 4'b0000, 3'd7, 1'b0, MODE_SHR);
    chk("shr_sat_mode_cycles", mode_cnt, 4);
    chk("shr_sat_rsp", rsp_data, 4'b0000);

    // 4: response back-pressure with a competing command offered
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 4'b0000);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_mode", {usr_s1, usr_s0}, 2'b00);
      chk("bp_a_par", a_par, 4'b0000);
    end
    cmd_valid = 1'b0;
    finish_rsp;
    tick;
    chk("bp_no_sneak", a_par, 4'b0000);

    // Hold command: no mode change, fill bit must not leak to serial inputs
    run_cmd(OP_HOLD, 4'b0000, 3'd3, 1'b1, MODE_SHR);
    chk("hold_no_shift", mode_cnt, 0);
    chk("hold_rsp", rsp_data, 4'b0000);
    finish_rsp;

    // 5: reset in the second cycle of a 4-cycle shift right
    run_cmd(OP_LOAD, 4'b0110, 3'd0, 1'b0, MODE_LOAD);
    chk("load_6_rsp", rsp_data, 4'b0110);
    finish_rsp;
    cmd_valid = 1'b1;
    cmd_op    = OP_SHR;
    cmd_count = 3'd4;
    cmd_fill  = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk("mid_first_mode", {usr_s1, usr_s0}, MODE_SHR);
    tick;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_mode", {usr_s1, usr_s0}, 2'b00);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp_data", rsp_data, 0);
      chk("mid_rst_msb", usr_MSB_in, 0);
      tick;
    end
    chk("mid_rst_partial", a_par, 4'b1011);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    tick;
    run_cmd(OP_LOAD, 4'b0011, 3'd0, 1'b0, MODE_LOAD);
    chk("post_rst_load_cycles", mode_cnt, 1);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_rsp", rsp_data, 4'b0011);
    finish_rsp;

`ifdef USR_ROTATE_EN
    // 6: rotates
    run_cmd(OP_LOAD, 4'b1000, 3'd0, 1'b0, MODE_LOAD);
    chk("rot_load_rsp", rsp_data, 4'b1000);
    finish_rsp;
    rot_sel = 1'b1;
    run_cmd(OP_SHR, 4'b0000, 3'd1, 1'b1, MODE_SHR);
    chk("rot_shr_rsp", rsp_data, 4'b0100);
    finish_rsp;
    run_cmd(OP_SHL, 4'b0000, 3'd2, 1'b1, MODE_SHL);
    chk("rot_shl_rsp", rsp_data, 4'b0001);
    finish_rsp;
    rot_sel = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
